data_sram_resp: RTL and testbench

//   Responder side of the data_sram interface driven by the EXE stage: single-port synchronous RAM

---
 rtl/data_sram_resp_pkg.sv | 35 +++
 rtl/data_sram_lane.sv | 27 ++
 rtl/data_sram_resp.sv | 129 ++++++++++++
 tb/tb_data_sram_resp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared data_sram bus widths, default geometry and lane layout so that EXE, MEM and
// the responder agree on one definition. The lane width grows by one bit (stored
// even parity) when DATA_SRAM_PARITY_EN is defined.
package data_sram_resp_pkg;

    // data_sram bus widths
    localparam int DATA_SRAM_EN_W       = 1;
    localparam int DATA_SRAM_WE_W       = 4;
    localparam int DATA_SRAM_ADDR_BUS_W = 32;
    localparam int DATA_SRAM_DATA_W     = 32;

    // default geometry: 2**14 words of 32 bits = 64 KiB mapped at byte address 0
    localparam int          DATA_SRAM_ADDR_W = 14;
    localparam logic [31:0] DATA_SRAM_BASE   = 32'h0000_0000;

`ifdef DATA_SRAM_PARITY_EN
    localparam int LANE_W = 9;   // {parity, byte}
`else
    localparam int LANE_W = 8;
`endif

    // classification of the request presented in the current cycle
    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_READ,
        ACC_WRITE,
        ACC_REJECT
    } acc_kind_t;

    // even parity: the stored bit makes the 9-bit lane XOR to zero
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/data_sram_lane.sv
// One byte lane of the data SRAM: 2**ADDR_W entries of W bits (8, or 9 with parity).
// Ports: clk; we = write this lane at idx; idx = word index; wdata = lane write data;
// rdata = current contents at idx (sampled by the top at the clock edge, so read-first).
module data_sram_lane #(
    parameter int ADDR_W = 14,
    parameter int W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [2**ADDR_W];

    // The top registers this value on the same edge that performs the write,
    // so a read-modify cycle returns the pre-write contents.
    assign rdata = mem[idx];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// data_sram responder: single-port RAM with byte enables, 1-cycle registered read data,
// alignment/range error pulses and saturating read/write counters.
// Ports: clk, reset (sync, active-high); data_sram_en/we/addr/wdata request from EXE;
// data_sram_rdata valid the cycle after the request; addr_err / align_err 1-cycle pulses;
// rd_cnt / wr_cnt accepted accesses. Optional macro DATA_SRAM_PARITY_EN adds per-lane
// even parity storage and the parity_err output.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          ADDR_W    = DATA_SRAM_ADDR_W,
    parameter logic [31:0] BASE_ADDR = DATA_SRAM_BASE,
    parameter int          CNT_W     = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            data_sram_en,
    input  logic [DATA_SRAM_WE_W-1:0]       data_sram_we,
    input  logic [DATA_SRAM_ADDR_BUS_W-1:0] data_sram_addr,
    input  logic [DATA_SRAM_DATA_W-1:0]     data_sram_wdata,
    output logic [DATA_SRAM_DATA_W-1:0]     data_sram_rdata,
    output logic                            addr_err,
    output logic                            align_err,
    output logic [CNT_W-1:0]                rd_cnt,
    output logic [CNT_W-1:0]                wr_cnt
`ifdef DATA_SRAM_PARITY_EN
    ,
    output logic                            parity_err
`endif
);

    logic [31:0]       offset;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    acc_kind_t         kind;
    logic [3:0]        lane_we;
    logic [LANE_W-1:0] lane_wdata [4];
    logic [LANE_W-1:0] lane_rdata [4];
    logic [31:0]       rd_word;

    // Addresses below BASE_ADDR wrap to a huge offset, so the explicit lower
    // bound is only a guard for that wrap; the upper bound is "no offset bits
    // above the word index".
    assign offset   = data_sram_addr - BASE_ADDR;
    assign in_range = (data_sram_addr >= BASE_ADDR) &&
                      ((offset >> (ADDR_W + 2)) == 32'd0);
    assign idx      = offset[ADDR_W+1:2];

    always_comb begin
        kind = ACC_IDLE;
        if (data_sram_en) begin
            if (!in_range) begin
                kind = ACC_REJECT;
            end else if (data_sram_we == '0) begin
                kind = ACC_READ;
            end else begin
                kind = ACC_WRITE;
            end
        end
    end

    // A write presented while reset is asserted is dropped along with its rdata.
    assign lane_we = (kind == ACC_WRITE && !reset) ? data_sram_we : 4'b0000;

    for (genvar i = 0; i < 4; i++) begin : g_lane
`ifdef DATA_SRAM_PARITY_EN
        assign lane_wdata[i] = {even_par(data_sram_wdata[8*i +: 8]), data_sram_wdata[8*i +: 8]};
`else
        assign lane_wdata[i] = data_sram_wdata[8*i +: 8];
`endif
        data_sram_lane #(
            .ADDR_W (ADDR_W),
            .W      (LANE_W)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .idx   (idx),
            .wdata (lane_wdata[i]),
            .rdata (lane_rdata[i])
        );
        assign rd_word[8*i +: 8] = lane_rdata[i][7:0];
    end

`ifdef DATA_SRAM_PARITY_EN
    logic [3:0] par_mism;
    for (genvar i = 0; i < 4; i++) begin : g_par
        assign par_mism[i] = ^lane_rdata[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= '0;
            addr_err        <= 1'b0;
            align_err       <= 1'b0;
            rd_cnt          <= '0;
            wr_cnt          <= '0;
`ifdef DATA_SRAM_PARITY_EN
            parity_err      <= 1'b0;
`endif
        end else begin
            addr_err  <= (kind == ACC_REJECT);
            align_err <= data_sram_en && (data_sram_addr[1:0] != 2'b00);
`ifdef DATA_SRAM_PARITY_EN
            parity_err <= (kind == ACC_READ) && (|par_mism);
`endif
            case (kind)
                ACC_READ: begin
                    data_sram_rdata <= rd_word;
                    if (rd_cnt != '1) begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                ACC_WRITE: begin
                    data_sram_rdata <= rd_word;
                    if (wr_cnt != '1) begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    end
                end
                ACC_REJECT: begin
                    data_sram_rdata <= '0;
                end
                default: begin
                    // idle: rdata and counters hold
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed scenarios followed by randomized traffic, with a
// byte-addressed reference model feeding a scoreboard queue that a monitor drains
// one entry per clock after each edge.
module tb_data_sram_resp;

    localparam int          ADDR_W    = 14;
    localparam logic [31:0] BASE      = 32'h0;
    localparam int          CNT_W     = 6;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;
    localparam longint      MEM_BYTES = 4 * (64'd1 << ADDR_W);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             data_sram_en = 1'b0;
    logic [3:0]       data_sram_we = 4'h0;
    logic [31:0]      data_sram_addr = 32'h0;
    logic [31:0]      data_sram_wdata = 32'h0;
    logic [31:0]      data_sram_rdata;
    logic             addr_err;
    logic             align_err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;
`ifdef DATA_SRAM_PARITY_EN
    logic             parity_err;
`endif

    always #5 clk = ~clk;

    data_sram_resp #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .addr_err        (addr_err),
        .align_err       (align_err),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
`ifdef DATA_SRAM_PARITY_EN
        ,
        .parity_err      (parity_err)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] mask;    // bytes of rdata whose value is known
        logic        aerr;
        logic        alerr;
        int          rd;
        int          wr;
        bit          chk_par;
        logic        par;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // reference model state: memory as individual bytes keyed by byte address
    logic [7:0]  mem_b [int unsigned];
    bit          par_bad [int unsigned];
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_mask  = 32'hFFFF_FFFF;
    int          m_rd = 0;
    int          m_wr = 0;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] mask);
        total++;
        if (((act ^ exp) & mask) != 32'h0 || $isunknown(act & mask)) begin
            bad++;
            $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act, exp, mask, $time);
        end
    endtask

    // Drive one request for the next edge and queue what the outputs must show after it.
    task automatic drive(input bit rst, input bit en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        bit          inr;
        int unsigned wbase;
        @(negedge clk);
        reset           = rst;
        data_sram_en    = en;
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wd;
        inr = ({32'h0, addr} >= {32'h0, BASE}) && ({32'h0, addr} < {32'h0, BASE} + MEM_BYTES);
        e.chk_par = 1'b1;
        e.par     = 1'b0;
        if (rst) begin
            m_rdata = 32'h0;
            m_mask  = 32'hFFFF_FFFF;
            m_rd    = 0;
            m_wr    = 0;
            e.aerr  = 1'b0;
            e.alerr = 1'b0;
        end else begin
            e.aerr  = en && !inr;
            e.alerr = en && (addr[1:0] != 2'b00);
            if (en && inr) begin
                wbase  = addr & 32'hFFFF_FFFC;
                m_mask = 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (mem_b.exists(wbase + b)) begin
                        m_rdata[8*b +: 8] = mem_b[wbase + b];
                        m_mask[8*b +: 8]  = 8'hFF;
                    end
                end
                if (we == 4'h0) begin
                    m_rd      = sat(m_rd + 1);
                    e.chk_par = (m_mask == 32'hFFFF_FFFF);
                    e.par     = par_bad.exists(wbase);
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (we[b]) mem_b[wbase + b] = wd[8*b +: 8];
                    end
                    if (we[2]) par_bad.delete(wbase);
                    m_wr = sat(m_wr + 1);
                end
            end else if (en) begin
                m_rdata = 32'h0;
                m_mask  = 32'hFFFF_FFFF;
            end
        end
        e.rdata = m_rdata;
        e.mask  = m_mask;
        e.rd    = m_rd;
        e.wr    = m_wr;
        sbq.push_back(e);
    endtask

    exp_t me;
    always begin
        @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            me = sbq.pop_front();
            if (me.mask != 32'h0) chk("rdata", data_sram_rdata, me.rdata, me.mask);
            chk("addr_err", {31'h0, addr_err}, {31'h0, me.aerr}, 32'h1);
            chk("align_err", {31'h0, align_err}, {31'h0, me.alerr}, 32'h1);
            chk("rd_cnt", 32'(rd_cnt), me.rd, 32'hFFFF_FFFF);
            chk("wr_cnt", 32'(wr_cnt), me.wr, 32'hFFFF_FFFF);
`ifdef DATA_SRAM_PARITY_EN
            if (me.chk_par) chk("parity_err", {31'h0, parity_err}, {31'h0, me.par}, 32'h1);
`endif
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  we;
        int          sel;

        // reset state
        drive(1, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 4'h0, 32'h0, 32'h0);

        // read word 0 (contents unknown), then reset clears rd_cnt
        drive(0, 1, 4'h0, 32'h0, 32'h0);
        drive(1, 0, 4'h0, 32'h0, 32'h0);

        // full write then read back
        drive(0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        drive(0, 1, 4'h0, 32'h10, 32'h0);

        // single byte lane write returns old data, then merged data
        drive(0, 1, 4'b0010, 32'h10, 32'h0000_AA00);
        drive(0, 1, 4'h0, 32'h10, 32'h0);

        // range boundary: top word in, next byte out; out-of-range write must not alias
        drive(0, 1, 4'hF, 32'hFFFC, 32'h1234_5678);
        drive(0, 1, 4'h0, 32'h10000, 32'h0);
        drive(0, 1, 4'h0, 32'hFFFC, 32'h0);
        drive(0, 1, 4'hF, 32'h10010, 32'h5555_5555);
        drive(0, 1, 4'h0, 32'hFFFFFFFC, 32'h0);
        drive(0, 1, 4'h0, 32'h10, 32'h0);

        // misaligned read, then idle holds rdata and clears flags
        drive(0, 1, 4'h0, 32'h13, 32'h0);
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        // both flags together
        drive(0, 1, 4'h0, 32'h10001, 32'h0);
        // reset while a read is in flight
        drive(0, 1, 4'h0, 32'hFFFC, 32'h0);
        drive(1, 1, 4'h0, 32'h10, 32'h0);

`ifdef DATA_SRAM_PARITY_EN
        drive(0, 1, 4'hF, 32'h20, 32'h1122_3344);
        drive(0, 1, 4'h0, 32'h20, 32'h0);
        drive(0, 0, 4'h0, 32'h0, 32'h0);
        dut.g_lane[2].u_lane.mem[8][8] = ~dut.g_lane[2].u_lane.mem[8][8];
        par_bad[32'h20] = 1'b1;
        drive(0, 1, 4'h0, 32'h20, 32'h0);
        drive(0, 0, 4'h0, 32'h0, 32'h0);
`endif

        // randomized traffic; counters saturate along the way
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: a = 32'($urandom_range(0, 15)) * 4;
                3:       a = 32'hFFF0 + 32'($urandom_range(0, 3)) * 4;
                4:       a = 32'h10000 + 32'($urandom_range(0, 3)) * 4;
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            wd = $urandom;
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0)
                drive(1, 1, 4'h0, a, wd);
            else
                drive(0, ($urandom_range(0, 4) != 0), we, a, wd);
        end

        @(posedge clk);
        #2;
        chk("drain", 32'(sbq.size()), 32'd0, 32'hFFFF_FFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
